// File: rtl/display_scan_driver.sv
// Time-multiplexed 7-segment scanner: steps one digit per slot with dead time, leading-zero
// blanking, per-digit enable and tear-free frame updates through a pending/shadow pair.
module display_scan_driver #(
  parameter int unsigned N_DIGITS    = 8,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [4*N_DIGITS-1:0] value_i,
  input  logic                  upd_i,
  input  logic                  bcd_mode_i,
  input  logic                  blank_lz_i,
  input  logic [N_DIGITS-1:0]   digit_en_i,
  output logic [3:0]            digit_val_o,
  output logic                  dec_trigger_o,
  output logic [N_DIGITS-1:0]   an_o,
  output logic                  frame_done_o
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned ValW = 4 * N_DIGITS;

  typedef enum logic [0:0] {StBlank, StShow} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [ValW-1:0]     shadow_q, shadow_d;
  logic [ValW-1:0]     pending_q, pending_d;
  logic                pend_v_q, pend_v_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [3:0]          digit_val_q, digit_val_d;
  logic                dec_trig_q, dec_trig_d;
  logic                frame_done_q, frame_done_d;

  logic                wrap, boundary, masked, zero_acc;
  logic [N_DIGITS-1:0] zero_above;

  always_comb begin
    wrap     = (cnt_q == CntW'(REFRESH_DIV - 1));
    boundary = wrap && (idx_q == IdxW'(N_DIGITS - 1));
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (wrap) begin
      idx_d = boundary ? '0 : idx_q + 1'b1;
    end

    shadow_d  = shadow_q;
    pending_d = pending_q;
    pend_v_d  = pend_v_q;
    // An update landing on the boundary cycle goes straight to the shadow for the new frame.
    if (upd_i) begin
      if (boundary) begin
        shadow_d = value_i;
        pend_v_d = 1'b0;
      end else begin
        pending_d = value_i;
        pend_v_d  = 1'b1;
      end
    end else if (boundary && pend_v_q) begin
      shadow_d = pending_q;
      pend_v_d = 1'b0;
    end

    state_d = (cnt_d < CntW'(DEAD_CYCLES)) ? StBlank : StShow;

    // zero_above[k]: nibbles k..N_DIGITS-1 of the next shadow are all zero.
    zero_acc   = 1'b1;
    zero_above = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_acc      = zero_acc && (shadow_d[4*k +: 4] == 4'h0);
      zero_above[k] = zero_acc;
    end

    masked = !digit_en_i[idx_d] || (blank_lz_i && (idx_d != '0) && zero_above[idx_d]);

    an_d = '1;
    if (state_d == StShow && !masked) begin
      an_d[idx_d] = 1'b0;
    end

    digit_val_d  = (cnt_d == '0) ? shadow_d[4*idx_d +: 4] : digit_val_q;
    dec_trig_d   = (cnt_d == '0) ? bcd_mode_i : dec_trig_q;
    frame_done_d = boundary;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= StBlank;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      pending_q    <= '0;
      pend_v_q     <= 1'b0;
      an_q         <= '1;
      digit_val_q  <= 4'h0;
      dec_trig_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pend_v_q     <= pend_v_d;
      an_q         <= an_d;
      digit_val_q  <= digit_val_d;
      dec_trig_q   <= dec_trig_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an_o          = an_q;
  assign digit_val_o   = digit_val_q;
  assign dec_trigger_o = dec_trig_q;
  assign frame_done_o  = frame_done_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Randomised bench for display_scan_driver; expectations come from a time-based model
// (slot = cycles/REFRESH_DIV) rather than from any state machine.
module tb_display_scan_driver;

  localparam int unsigned N = 8;
  localparam int unsigned R = 4;
  localparam int unsigned D = 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   value = '0;
  logic          upd = 1'b0;
  logic          bcd_mode = 1'b0;
  logic          blank_lz = 1'b0;
  logic [N-1:0]  digit_en = '1;
  logic [3:0]    digit_val;
  logic          dec_trigger;
  logic [N-1:0]  an;
  logic          frame_done;

  int unsigned checks = 0;
  int unsigned passed = 0;

  // Reference model state
  int unsigned t;
  logic [31:0] m_shadow, m_pend;
  bit          m_pv;
  logic [7:0]  e_an;
  logic [3:0]  e_dv;
  logic        e_dt, e_fd;

  display_scan_driver #(
    .N_DIGITS   (N),
    .REFRESH_DIV(R),
    .DEAD_CYCLES(D)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .value_i      (value),
    .upd_i        (upd),
    .bcd_mode_i   (bcd_mode),
    .blank_lz_i   (blank_lz),
    .digit_en_i   (digit_en),
    .digit_val_o  (digit_val),
    .dec_trigger_o(dec_trigger),
    .an_o         (an),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  function automatic int unsigned m_cnt();
    return t % R;
  endfunction

  function automatic int unsigned m_idx();
    return (t / R) % N;
  endfunction

  task automatic model_reset();
    t        = 0;
    m_shadow = '0;
    m_pend   = '0;
    m_pv     = 1'b0;
    e_an     = 8'hFF;
    e_dv     = 4'h0;
    e_dt     = 1'b0;
    e_fd     = 1'b0;
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    bit          bnd, msk;
    int unsigned idx;
    logic [7:0]  onehot;
    @(posedge clk);
    bnd = (m_cnt() == R - 1) && (m_idx() == N - 1);
    if (upd) begin
      if (bnd) begin
        m_shadow = value;
        m_pv     = 1'b0;
      end else begin
        m_pend = value;
        m_pv   = 1'b1;
      end
    end else if (bnd && m_pv) begin
      m_shadow = m_pend;
      m_pv     = 1'b0;
    end
    t++;
    idx  = m_idx();
    e_fd = bnd;
    e_dv = m_shadow[4*idx +: 4];
    if (m_cnt() == 0) e_dt = bcd_mode;
    msk    = !digit_en[idx] || (blank_lz && idx > 0 && (m_shadow >> (4 * idx)) == 32'h0);
    onehot = 8'h01 << idx;
    e_an   = (m_cnt() < D || msk) ? 8'hFF : ~onehot;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #12;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({an, digit_val, dec_trigger, frame_done} !== {8'hFF, 4'h0, 1'b0, 1'b0}) begin
      $display("FAIL reset: got an=%h dv=%h dt=%b fd=%b want an=ff dv=0 dt=0 fd=0",
               an, digit_val, dec_trigger, frame_done);
    end else passed++;
  endtask

  task automatic test_scan();
    int fd_seen = 0;
    value = 32'h1234_5678;
    upd   = 1'b1;
    tick();
    upd = 1'b0;
    for (int i = 0; i < 3 * N * R; i++) begin
      tick();
      if (frame_done) fd_seen++;
      checks++;
      if ({an, digit_val, dec_trigger, frame_done} !== {e_an, e_dv, e_dt, e_fd}) begin
        $display("FAIL scan t=%0d: got an=%h dv=%h dt=%b fd=%b want an=%h dv=%h dt=%b fd=%b",
                 t, an, digit_val, dec_trigger, frame_done, e_an, e_dv, e_dt, e_fd);
      end else passed++;
    end
    checks++;
    if (fd_seen != 3) $display("FAIL frame_done_count: got %0d want 3", fd_seen);
    else passed++;
  endtask

  task automatic test_midframe_update();
    while (m_idx() != 3) tick();
    value = 32'hAAAA_AAAA;
    upd   = 1'b1;
    tick();
    upd = 1'b0;
    for (int i = 0; i < 2 * N * R; i++) begin
      // Land a fresh update exactly on a boundary cycle.
      if (m_cnt() == R - 1 && m_idx() == N - 1 && i > N * R) begin
        value = $urandom;
        upd   = 1'b1;
      end
      tick();
      upd = 1'b0;
      checks++;
      if ({an, digit_val, dec_trigger, frame_done} !== {e_an, e_dv, e_dt, e_fd}) begin
        $display("FAIL midframe t=%0d: got an=%h dv=%h dt=%b fd=%b want an=%h dv=%h dt=%b fd=%b",
                 t, an, digit_val, dec_trigger, frame_done, e_an, e_dv, e_dt, e_fd);
      end else passed++;
    end
  endtask

  task automatic test_blank_lz();
    logic [31:0] vals [2];
    vals[0] = 32'h0000_0420;
    vals[1] = 32'h0000_0000;
    blank_lz = 1'b1;
    for (int v = 0; v < 2; v++) begin
      value = vals[v];
      upd   = 1'b1;
      tick();
      upd = 1'b0;
      for (int i = 0; i < 2 * N * R; i++) begin
        tick();
        checks++;
        if ({an, digit_val, dec_trigger, frame_done} !== {e_an, e_dv, e_dt, e_fd}) begin
          $display("FAIL blank_lz t=%0d: got an=%h dv=%h dt=%b fd=%b want an=%h dv=%h dt=%b fd=%b",
                   t, an, digit_val, dec_trigger, frame_done, e_an, e_dv, e_dt, e_fd);
        end else passed++;
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_digit_en();
    digit_en = 8'b1111_0000;
    value    = $urandom;
    upd      = 1'b1;
    tick();
    upd = 1'b0;
    for (int i = 0; i < 2 * N * R; i++) begin
      tick();
      checks++;
      if ({an, digit_val, dec_trigger, frame_done} !== {e_an, e_dv, e_dt, e_fd}) begin
        $display("FAIL digit_en t=%0d: got an=%h dv=%h dt=%b fd=%b want an=%h dv=%h dt=%b fd=%b",
                 t, an, digit_val, dec_trigger, frame_done, e_an, e_dv, e_dt, e_fd);
      end else passed++;
    end
    digit_en = '1;
  endtask

  task automatic test_bcd_mode();
    for (int i = 0; i < 2 * N * R; i++) begin
      if ($urandom_range(0, 2) == 0) bcd_mode = ~bcd_mode;
      tick();
      checks++;
      if ({an, digit_val, dec_trigger, frame_done} !== {e_an, e_dv, e_dt, e_fd}) begin
        $display("FAIL bcd_mode t=%0d: got an=%h dv=%h dt=%b fd=%b want an=%h dv=%h dt=%b fd=%b",
                 t, an, digit_val, dec_trigger, frame_done, e_an, e_dv, e_dt, e_fd);
      end else passed++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      upd = ($urandom_range(0, 7) == 0);
      if (upd) value = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h000F_FFFF) : $urandom;
      if ($urandom_range(0, 15) == 0) digit_en = $urandom;
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 9) == 0) bcd_mode = ~bcd_mode;
      tick();
      checks++;
      if ({an, digit_val, dec_trigger, frame_done} !== {e_an, e_dv, e_dt, e_fd}) begin
        $display("FAIL random t=%0d: got an=%h dv=%h dt=%b fd=%b want an=%h dv=%h dt=%b fd=%b",
                 t, an, digit_val, dec_trigger, frame_done, e_an, e_dv, e_dt, e_fd);
      end else passed++;
    end
    upd      = 1'b0;
    digit_en = '1;
    blank_lz = 1'b0;
  endtask

  task automatic test_async_reset();
    value = 32'h9876_5432;
    upd   = 1'b1;
    tick();
    upd = 1'b0;
    while (!(m_idx() == 5 && m_cnt() == 2)) tick();
    // Leave an update pending; reset must discard it.
    value = 32'hDEAD_BEEF;
    upd   = 1'b1;
    tick();
    upd     = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({an, digit_val, frame_done} !== {8'hFF, 4'h0, 1'b0}) begin
      $display("FAIL async_reset: got an=%h dv=%h fd=%b want an=ff dv=0 fd=0",
               an, digit_val, frame_done);
    end else passed++;
    #10;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * N * R; i++) begin
      tick();
      checks++;
      if ({an, digit_val, dec_trigger, frame_done} !== {e_an, e_dv, e_dt, e_fd}) begin
        $display("FAIL post_reset t=%0d: got an=%h dv=%h dt=%b fd=%b want an=%h dv=%h dt=%b fd=%b",
                 t, an, digit_val, dec_trigger, frame_done, e_an, e_dv, e_dt, e_fd);
      end else passed++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan();
    test_midframe_update();
    test_blank_lz();
    test_digit_en();
    test_bcd_mode();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
